// File: rtl/cond_unit_mt.sv
// Execute-stage ARM condition unit with NUM_CTX independent NZCV flag contexts.
// Optional squashed-instruction counter enabled by defining COND_PERF_CNT_EN.
module cond_unit_mt #(
  parameter int unsigned NUM_CTX = 2,
  parameter int unsigned CTX_W   = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ValidE,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [CTX_W-1:0] CtxE,
  input  logic [3:0]       CondE,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagWE,
  input  logic             PCSE,
  input  logic             RegWE,
  input  logic             MemWE,
  output logic             PCSrcE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             CondExE,
  output logic [3:0]       FlagsE,
  output logic [CNT_W-1:0] SquashCnt
);

  localparam int unsigned FLAG_W = 4;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  logic [FLAG_W-1:0] flags_q [NUM_CTX];
  logic [FLAG_W-1:0] flags_d [NUM_CTX];

  logic              ctx_ok_c;
  logic [FLAG_W-1:0] sel_flags_c;
  logic              cond_pass_c;
  logic              cond_ok_c;
  logic              live_c;
  logic              commit_c;
  logic              flag_n, flag_z, flag_c, flag_v;

  // Context lookup; out-of-range selects read as all-zero and never pass.
  always_comb begin
    ctx_ok_c    = 1'b0;
    sel_flags_c = '0;
    for (int i = 0; i < int'(NUM_CTX); i++) begin
      if (CtxE == CTX_W'(i)) begin
        ctx_ok_c    = 1'b1;
        sel_flags_c = flags_q[i];
      end
    end
  end

  assign flag_n = sel_flags_c[3];
  assign flag_z = sel_flags_c[2];
  assign flag_c = sel_flags_c[1];
  assign flag_v = sel_flags_c[0];

  // Condition decode against stored flags only (no ALU bypass).
  always_comb begin
    cond_pass_c = 1'b0;
    case (CondE)
      COND_EQ: cond_pass_c = flag_z;
      COND_NE: cond_pass_c = ~flag_z;
      COND_CS: cond_pass_c = flag_c;
      COND_CC: cond_pass_c = ~flag_c;
      COND_MI: cond_pass_c = flag_n;
      COND_PL: cond_pass_c = ~flag_n;
      COND_VS: cond_pass_c = flag_v;
      COND_VC: cond_pass_c = ~flag_v;
      COND_HI: cond_pass_c = flag_c & ~flag_z;
      COND_LS: cond_pass_c = ~flag_c | flag_z;
      COND_GE: cond_pass_c = (flag_n == flag_v);
      COND_LT: cond_pass_c = (flag_n != flag_v);
      COND_GT: cond_pass_c = ~flag_z & (flag_n == flag_v);
      COND_LE: cond_pass_c = flag_z | (flag_n != flag_v);
      COND_AL: cond_pass_c = 1'b1;
      default: cond_pass_c = 1'b0;
    endcase
  end

  assign live_c    = ValidE & ~FlushE & ~RESET;
  assign cond_ok_c = ctx_ok_c & cond_pass_c;
  assign commit_c  = live_c & cond_ok_c & ~StallE;

  // Request gating is combinational; stall gating belongs to the hazard unit.
  assign CondExE   = live_c & cond_ok_c;
  assign PCSrcE    = CondExE & PCSE;
  assign RegWriteE = CondExE & RegWE;
  assign MemWriteE = CondExE & MemWE;
  assign FlagsE    = sel_flags_c;

  // Group-wise flag commit into the selected context only.
  always_comb begin
    for (int i = 0; i < int'(NUM_CTX); i++) begin
      flags_d[i] = flags_q[i];
      if (commit_c && (CtxE == CTX_W'(i))) begin
        if (FlagWE[1]) flags_d[i][3:2] = ALUFlags[3:2];
        if (FlagWE[0]) flags_d[i][1:0] = ALUFlags[1:0];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < int'(NUM_CTX); i++) flags_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CTX); i++) flags_q[i] <= flags_d[i];
    end
  end

`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] squash_cnt_q;
  logic [CNT_W-1:0] squash_cnt_d;

  // Saturating count of live instructions that fail their condition.
  always_comb begin
    squash_cnt_d = squash_cnt_q;
    if (live_c && !cond_ok_c && !StallE && !(&squash_cnt_q)) begin
      squash_cnt_d = squash_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) squash_cnt_q <= '0;
    else       squash_cnt_q <= squash_cnt_d;
  end

  assign SquashCnt = squash_cnt_q;
`else
  assign SquashCnt = '0;
`endif

endmodule

// File: tb/tb_cond_unit_mt.sv
// Directed table-driven bench for cond_unit_mt (3 contexts, 2-bit select, 2-bit counter).
module tb_cond_unit_mt;

  logic       CLK;
  logic       RESET;
  logic       ValidE, StallE, FlushE;
  logic [1:0] CtxE;
  logic [3:0] CondE, ALUFlags;
  logic [1:0] FlagWE;
  logic       PCSE, RegWE, MemWE;
  logic       PCSrcE, RegWriteE, MemWriteE, CondExE;
  logic [3:0] FlagsE;
  logic [1:0] SquashCnt;

  int errors = 0;
  int checks = 0;

  cond_unit_mt #(.NUM_CTX(3), .CTX_W(2), .CNT_W(2)) dut (
    .CLK(CLK), .RESET(RESET), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
    .CtxE(CtxE), .CondE(CondE), .ALUFlags(ALUFlags), .FlagWE(FlagWE),
    .PCSE(PCSE), .RegWE(RegWE), .MemWE(MemWE),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .CondExE(CondExE), .FlagsE(FlagsE), .SquashCnt(SquashCnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] ctx;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] fwe;
    logic       pcs, rw, mw, v, st, fl;
    logic [7:0] exp;   // {PCSrcE, RegWriteE, MemWriteE, CondExE, FlagsE}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [1:0] ctx, logic [3:0] cond, logic [3:0] alu,
                              logic [1:0] fwe, logic pcs, logic rw, logic mw,
                              logic v, logic st, logic fl, logic [7:0] exp);
    vec_t r;
    r.ctx = ctx; r.cond = cond; r.alu = alu; r.fwe = fwe;
    r.pcs = pcs; r.rw = rw; r.mw = mw; r.v = v; r.st = st; r.fl = fl;
    r.exp = exp;
    return r;
  endfunction

  task automatic drive(vec_t t);
    CtxE = t.ctx; CondE = t.cond; ALUFlags = t.alu; FlagWE = t.fwe;
    PCSE = t.pcs; RegWE = t.rw; MemWE = t.mw;
    ValidE = t.v; StallE = t.st; FlushE = t.fl;
  endtask

  task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {PCSrcE, RegWriteE, MemWriteE, CondExE, FlagsE};
  endfunction

  logic [1:0] exp_sq;

  initial begin
    // After reset every context is 0000.
    vecs.push_back(mk(0, 4'hE, 4'b0100, 2'b10, 0,0,0, 1,0,0, 8'b0001_0000));
    vecs.push_back(mk(0, 4'h0, 4'b0000, 2'b00, 0,1,0, 1,0,0, 8'b0101_0100));
    vecs.push_back(mk(1, 4'h0, 4'b0000, 2'b00, 0,1,0, 1,0,0, 8'b0000_0000));
    vecs.push_back(mk(0, 4'hE, 4'b0000, 2'b00, 0,0,0, 1,0,0, 8'b0001_0100));
    vecs.push_back(mk(1, 4'hE, 4'b1111, 2'b01, 0,0,0, 1,0,0, 8'b0001_0000));
    vecs.push_back(mk(1, 4'h8, 4'b0000, 2'b00, 1,0,0, 1,0,0, 8'b1001_0011));
    vecs.push_back(mk(0, 4'h1, 4'b1010, 2'b11, 1,0,0, 1,0,0, 8'b0000_0100));
    vecs.push_back(mk(0, 4'h0, 4'b1010, 2'b11, 1,0,0, 1,1,0, 8'b1001_0100));
    vecs.push_back(mk(0, 4'hE, 4'b0000, 2'b00, 0,0,0, 1,0,0, 8'b0001_0100));
    vecs.push_back(mk(0, 4'hF, 4'b1111, 2'b11, 1,1,1, 1,0,0, 8'b0000_0100));
    vecs.push_back(mk(0, 4'hE, 4'b1111, 2'b11, 1,0,1, 1,0,1, 8'b0000_0100));
    vecs.push_back(mk(0, 4'hE, 4'b0000, 2'b11, 0,0,0, 1,1,1, 8'b0000_0100));
    vecs.push_back(mk(0, 4'hE, 4'b0000, 2'b00, 0,1,0, 0,0,0, 8'b0000_0100));
    vecs.push_back(mk(0, 4'hE, 4'b0000, 2'b00, 0,0,0, 1,0,0, 8'b0001_0100));
    // Context 1 holds N=0 Z=0 C=1 V=1.
    vecs.push_back(mk(1, 4'h2, 4'b0000, 2'b00, 0,1,1, 1,0,0, 8'b0111_0011));
    vecs.push_back(mk(1, 4'h3, 4'b0000, 2'b00, 0,1,1, 1,0,0, 8'b0000_0011));
    vecs.push_back(mk(1, 4'h4, 4'b0000, 2'b00, 0,1,1, 1,0,0, 8'b0000_0011));
    vecs.push_back(mk(1, 4'h5, 4'b0000, 2'b00, 0,1,1, 1,0,0, 8'b0111_0011));
    vecs.push_back(mk(1, 4'h6, 4'b0000, 2'b00, 0,1,1, 1,0,0, 8'b0111_0011));
    vecs.push_back(mk(1, 4'h7, 4'b0000, 2'b00, 0,1,1, 1,0,0, 8'b0000_0011));
    vecs.push_back(mk(1, 4'h9, 4'b0000, 2'b00, 0,1,1, 1,0,0, 8'b0000_0011));
    vecs.push_back(mk(1, 4'hA, 4'b0000, 2'b00, 0,1,1, 1,0,0, 8'b0000_0011));
    vecs.push_back(mk(1, 4'hB, 4'b0000, 2'b00, 0,1,1, 1,0,0, 8'b0111_0011));
    vecs.push_back(mk(1, 4'hC, 4'b0000, 2'b00, 0,1,1, 1,0,0, 8'b0000_0011));
    vecs.push_back(mk(1, 4'hD, 4'b0000, 2'b00, 0,1,1, 1,0,0, 8'b0111_0011));
    // Out-of-range context 3 is a no-op; context 2 untouched.
    vecs.push_back(mk(3, 4'hE, 4'b1111, 2'b11, 1,1,1, 1,0,0, 8'b0000_0000));
    vecs.push_back(mk(2, 4'hE, 4'b0000, 2'b00, 0,0,0, 1,0,0, 8'b0001_0000));
    vecs.push_back(mk(0, 4'hE, 4'b1001, 2'b11, 0,0,0, 1,0,0, 8'b0001_0100));
    vecs.push_back(mk(0, 4'hA, 4'b0000, 2'b00, 0,1,0, 1,0,0, 8'b0101_1001));
    vecs.push_back(mk(0, 4'hB, 4'b0000, 2'b00, 0,1,0, 1,0,0, 8'b0000_1001));
    vecs.push_back(mk(1, 4'hE, 4'b0000, 2'b00, 0,0,0, 1,0,0, 8'b0001_0011));

    RESET = 1'b1;
    drive(mk(0, 4'hE, 4'b1111, 2'b11, 1,1,1, 1,0,0, 8'h00));
    @(negedge CLK);
    #1;
    chk("reset_outs", 0, outs(), 8'b0000_0000);
    chk("reset_sq", 0, {6'd0, SquashCnt}, 8'd0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      chk("vec", i, outs(), vecs[i].exp);
      @(negedge CLK);
    end

`ifdef COND_PERF_CNT_EN
    exp_sq = 2'd3;
`else
    exp_sq = 2'd0;
`endif
    chk("squash_sat", 0, {6'd0, SquashCnt}, {6'd0, exp_sq});

    // Async reset mid-operation: load ctx1 = 1010, then reset between edges.
    drive(mk(1, 4'hE, 4'b1010, 2'b11, 0,0,0, 1,0,0, 8'h00));
    @(negedge CLK);
    drive(mk(1, 4'hE, 4'b0000, 2'b00, 0,1,0, 1,0,0, 8'h00));
    #1;
    chk("ctx1_loaded", 0, outs(), 8'b0101_1010);
    RESET = 1'b1;
    #1;
    chk("async_rst", 0, outs(), 8'b0000_0000);
    chk("async_rst_sq", 0, {6'd0, SquashCnt}, 8'd0);
    @(negedge CLK);
    RESET = 1'b0;
    drive(mk(1, 4'hE, 4'b0101, 2'b11, 0,0,0, 1,0,0, 8'h00));
    #1;
    chk("post_rst", 0, outs(), 8'b0001_0000);
    @(negedge CLK);
    drive(mk(1, 4'hE, 4'b0000, 2'b00, 0,0,0, 1,0,0, 8'h00));
    #1;
    chk("post_rst_commit", 0, outs(), 8'b0001_0101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
